// File: rtl/julia_pixel_engine_if.sv
// Word-output channel of the Julia pixel engine: packed pixel word plus word address,
// moved with a valid/ready handshake toward the SDRAM write sequencer.
interface julia_pixel_engine_if;
  logic [31:0] o_Data;
  logic [21:0] o_Address;
  logic        o_Valid;
  logic        i_Ready;

  modport master (output o_Data, o_Address, o_Valid, input i_Ready);
  modport slave  (input o_Data, o_Address, o_Valid, output i_Ready);
endinterface

// File: rtl/julia_pixel_engine.sv
// Julia-set escape-count engine: iterates z <- z^2 + c per pixel in signed fixed point,
// packs four 8-bit counts per word and streams words with their addresses.
module julia_pixel_engine #(
  parameter int X_PX     = 800,
  parameter int Y_PX     = 480,
  parameter int W        = 16,
  parameter int FRAC     = 12,
  parameter int MAX_ITER = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_Start,
  input  logic signed [W-1:0] i_CX,
  input  logic signed [W-1:0] i_CY,
  input  logic signed [W-1:0] i_X0,
  input  logic signed [W-1:0] i_Y0,
  input  logic signed [W-1:0] i_Step,
  julia_pixel_engine_if.master wr,
  output logic                o_Busy,
  output logic                o_Done
);
  localparam int PXW = $clog2(X_PX + 1);
  localparam int PYW = $clog2(Y_PX + 1);
  // Escape threshold 4.0 expressed in the 2*FRAC product scale, sized to the sum width.
  localparam logic signed [2*W:0] ESC_LIM = {{(2*W-2*FRAC-2){1'b0}}, 3'b100, {(2*FRAC){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ADD, S_STORE, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic signed [W-1:0]   cx_q, cy_q, x0_q, step_q, cur_x_q, cur_y_q, zx_q, zy_q;
  logic signed [2*W-1:0] xx_q, yy_q, xy_q;
  logic [PXW-1:0]        px_q;
  logic [PYW-1:0]        py_q;
  logic [7:0]            iter_q;
  logic [2:0][7:0]       pack_q;
  logic [31:0]           data_q;
  logic [21:0]           addr_q, wcnt_q;
  logic                  valid_q, busy_q, done_q;

  logic signed [2*W:0] xx_e, yy_e, xy_e, mag, diff, dbl;
  logic signed [W-1:0] zx_new, zy_new;
  logic [1:0]          lane;
  logic                escape, last_col, last_row, accept, out_free;
  logic                start_frame, advance, load_word, done_set;

  assign xx_e     = xx_q;
  assign yy_e     = yy_q;
  assign xy_e     = xy_q;
  assign mag      = xx_e + yy_e;
  assign diff     = xx_e - yy_e;
  assign dbl      = xy_e <<< 1;
  assign zx_new   = W'(diff >>> FRAC) + cx_q;
  assign zy_new   = W'(dbl >>> FRAC) + cy_q;
  assign escape   = (mag > ESC_LIM) || (iter_q == 8'(MAX_ITER));
  assign lane     = px_q[1:0];
  assign last_col = (px_q == PXW'(X_PX - 1));
  assign last_row = (py_q == PYW'(Y_PX - 1));
  assign accept   = valid_q && wr.i_Ready;
  assign out_free = !valid_q || wr.i_Ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    advance     = 1'b0;
    load_word   = 1'b0;
    done_set    = 1'b0;
    case (state_q)
      S_IDLE:  if (i_Start) begin
                 start_frame = 1'b1;
                 state_d     = S_LOAD;
               end
      S_LOAD:  state_d = S_MUL;
      S_MUL:   state_d = S_ADD;
      S_ADD:   state_d = escape ? S_STORE : S_MUL;
      // A completed word waits here until the output register can take it.
      S_STORE: if (lane != 2'd3 || out_free) begin
                 advance   = 1'b1;
                 load_word = (lane == 2'd3);
                 state_d   = (last_col && last_row) ? S_DRAIN : S_LOAD;
               end
      S_DRAIN: if (accept) begin
                 done_set = 1'b1;
                 state_d  = S_IDLE;
               end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cx_q <= '0; cy_q <= '0; x0_q <= '0; step_q <= '0;
      cur_x_q <= '0; cur_y_q <= '0; zx_q <= '0; zy_q <= '0;
      xx_q <= '0; yy_q <= '0; xy_q <= '0;
      px_q <= '0; py_q <= '0; iter_q <= '0; pack_q <= '0;
      data_q <= '0; addr_q <= '0; wcnt_q <= '0;
      valid_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      if (start_frame) begin
        cx_q <= i_CX; cy_q <= i_CY; x0_q <= i_X0; step_q <= i_Step;
        cur_x_q <= i_X0; cur_y_q <= i_Y0;
        px_q <= '0; py_q <= '0; wcnt_q <= '0;
        busy_q <= 1'b1;
      end
      if (state_q == S_LOAD) begin
        zx_q <= cur_x_q; zy_q <= cur_y_q; iter_q <= '0;
      end
      if (state_q == S_MUL) begin
        xx_q <= zx_q * zx_q; yy_q <= zy_q * zy_q; xy_q <= zx_q * zy_q;
      end
      if (state_q == S_ADD && !escape) begin
        zx_q <= zx_new; zy_q <= zy_new; iter_q <= iter_q + 8'd1;
      end
      if (advance) begin
        for (int i = 0; i < 3; i++)
          if (lane == 2'(i)) pack_q[i] <= iter_q;
        if (last_col) begin
          px_q <= '0; cur_x_q <= x0_q;
          py_q <= py_q + PYW'(1); cur_y_q <= cur_y_q + step_q;
        end else begin
          px_q <= px_q + PXW'(1); cur_x_q <= cur_x_q + step_q;
        end
      end
      if (load_word) begin
        data_q  <= {iter_q, pack_q};
        addr_q  <= wcnt_q;
        wcnt_q  <= wcnt_q + 22'd1;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      done_q <= done_set;
      if (done_set) busy_q <= 1'b0;
    end
  end

  assign wr.o_Data    = data_q;
  assign wr.o_Address = addr_q;
  assign wr.o_Valid   = valid_q;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
endmodule

// File: tb/tb_julia_pixel_engine.sv
// Bench for julia_pixel_engine on an 8x2 frame: directed and random frames checked
// against an integer escape-count model, plus handshake stalls and reset cases.
module tb_julia_pixel_engine;
  localparam int XP = 8;
  localparam int YP = 2;
  localparam int NW = XP * YP / 4;

  logic        clk = 1'b0;
  logic        reset, i_Start, ready, o_Busy, o_Done;
  logic [15:0] i_CX, i_CY, i_X0, i_Y0, i_Step;
  int          tests = 0;
  int          fails = 0;
  int          fn;

  julia_pixel_engine_if bus();
  assign bus.i_Ready = ready;

  julia_pixel_engine #(.X_PX(XP), .Y_PX(YP), .W(16), .FRAC(12), .MAX_ITER(255)) dut (
    .clk(clk), .reset(reset), .i_Start(i_Start),
    .i_CX(i_CX), .i_CY(i_CY), .i_X0(i_X0), .i_Y0(i_Y0), .i_Step(i_Step),
    .wr(bus.master), .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrap16(input longint v);
    logic [15:0] t;
    t = v[15:0];
    return longint'($signed(t));
  endfunction

  // Escape count of one point: square, test |z|^2 > 4, then add c, all in Q4.12 integers.
  function automatic int ref_count(input longint cr, input longint ci, input longint zr0, input longint zi0);
    longint zr, zi, rr, ii, ri;
    int res;
    zr = zr0; zi = zi0; res = -1;
    for (int k = 0; k <= 255 && res < 0; k++) begin
      rr = zr * zr; ii = zi * zi; ri = zr * zi;
      if (rr + ii > (longint'(4) <<< 24) || k == 255) res = k;
      else begin
        zr = wrap16(((rr - ii) >>> 12) + cr);
        zi = wrap16(((2 * ri) >>> 12) + ci);
      end
    end
    return res;
  endfunction

  task automatic run_frame(input string name, input logic [15:0] c_r, input logic [15:0] c_i,
                           input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] st,
                           input bit rnd_ready, input bit stall, input bit poke, output int first_n);
    logic [31:0] exp_d [NW];
    logic [31:0] pd;
    logic [21:0] pa;
    int          got, n, stall_left, p;
    bit          armed, done_seen, hold;
    for (int w = 0; w < NW; w++) begin
      exp_d[w] = '0;
      for (int j = 0; j < 4; j++) begin
        p = 4 * w + j;
        exp_d[w] |= 32'(ref_count(longint'($signed(c_r)), longint'($signed(c_i)),
                        wrap16(longint'($signed(x0)) + (p % XP) * longint'($signed(st))),
                        wrap16(longint'($signed(y0)) + (p / XP) * longint'($signed(st))))) << (8 * j);
      end
    end
    @(negedge clk);
    i_CX = c_r; i_CY = c_i; i_X0 = x0; i_Y0 = y0; i_Step = st; i_Start = 1'b1; ready = 1'b1;
    got = 0; n = 0; stall_left = 0; armed = stall; done_seen = 0; hold = 0; first_n = -1;
    pd = '0; pa = '0;
    while (!done_seen && n < 12000) begin
      @(negedge clk);
      n++;
      i_Start = 1'b0;
      if (poke && n == 10) begin
        i_Start = 1'b1; i_CX = ~c_r; i_X0 = ~x0; i_Step = ~st;
      end
      if (n == 1) check({name, ":busy_after_start"}, o_Busy, 1);
      if (hold) begin
        check({name, ":hold_valid"}, bus.o_Valid, 1);
        check({name, ":hold_data"}, bus.o_Data, pd);
        check({name, ":hold_addr"}, bus.o_Address, pa);
      end
      if (armed && bus.o_Valid && got >= 1) begin
        armed = 0; stall_left = 50;
      end
      if (stall_left > 0) begin
        ready = 1'b0; stall_left--;
      end else if (rnd_ready) ready = 1'($urandom_range(0, 1));
      else ready = 1'b1;
      if (first_n < 0 && bus.o_Valid) first_n = n;
      if (o_Done) begin
        done_seen = 1;
        check({name, ":words_before_done"}, got, NW);
        check({name, ":busy_at_done"}, o_Busy, 0);
      end else if (bus.o_Valid && ready) begin
        if (got < NW) begin
          check({name, ":addr"}, bus.o_Address, got);
          check({name, ":data"}, bus.o_Data, exp_d[got]);
        end
        $display("[TB] %s word %0d addr=%0d data=%08h expect=%08h cycle=%0d",
                 name, got, bus.o_Address, bus.o_Data, (got < NW) ? exp_d[got] : 32'h0, n);
        got++;
      end
      hold = bus.o_Valid && !ready;
      pd = bus.o_Data; pa = bus.o_Address;
    end
    check({name, ":done_within_budget"}, done_seen, 1);
    @(negedge clk);
    check({name, ":done_is_pulse"}, o_Done, 0);
    check({name, ":idle_not_busy"}, o_Busy, 0);
  endtask

  initial begin
    reset = 1'b1; i_Start = 1'b0; ready = 1'b1;
    i_CX = '0; i_CY = '0; i_X0 = '0; i_Y0 = '0; i_Step = '0;
    repeat (3) @(negedge clk);
    check("reset:valid", bus.o_Valid, 0);
    check("reset:busy", o_Busy, 0);
    check("reset:done", o_Done, 0);
    check("reset:data", bus.o_Data, 0);
    check("reset:addr", bus.o_Address, 0);
    reset = 1'b0;

    run_frame("all255", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, fn);
    run_frame("zero", 16'h0000, 16'h0000, 16'h3000, 16'h0000, 16'h0000, 0, 0, 0, fn);
    run_frame("one", 16'h0000, 16'h0000, 16'h1800, 16'h0000, 16'h0000, 0, 0, 0, fn);
    check("one:first_word_cycle", fn, 25);
    run_frame("grid", 16'hF400, 16'h019A, 16'hE000, 16'hF000, 16'h0100, 0, 0, 0, fn);

    for (int r = 0; r < 3; r++) begin
      run_frame($sformatf("rand%0d", r),
                16'(int'($urandom_range(0, 16383)) - 8192), 16'(int'($urandom_range(0, 16383)) - 8192),
                16'(int'($urandom_range(0, 8191)) - 8192), 16'(int'($urandom_range(0, 6143)) - 4096),
                16'($urandom_range(0, 1023)), 1, r == 0, r == 1, fn);
    end

    // Abort a frame while pixel 5 is in its multiply step.
    @(negedge clk);
    i_CX = '0; i_CY = '0; i_X0 = 16'h3000; i_Y0 = '0; i_Step = '0; i_Start = 1'b1; ready = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    repeat (21) @(negedge clk);
    check("abort:busy_before", o_Busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort:valid", bus.o_Valid, 0);
    check("abort:busy", o_Busy, 0);
    check("abort:addr", bus.o_Address, 0);
    run_frame("restart", 16'h0000, 16'h0000, 16'h1800, 16'h0000, 16'h0000, 0, 0, 0, fn);

    @(negedge clk);
    reset = 1'b1; i_Start = 1'b1;
    @(negedge clk);
    reset = 1'b0; i_Start = 1'b0;
    repeat (2) @(negedge clk);
    check("start_vs_reset:busy", o_Busy, 0);
    check("start_vs_reset:valid", bus.o_Valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
